// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and counter sizing for the HI/LO multiply/divide unit.
// Latency: n/a (constants only). Backpressure: n/a.
// Optional divide op (OP_DIV) is only decoded when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_MADD = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Iteration counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// Command/result bundle between an issuing pipeline (master) and muldiv_hilo (slave).
// Latency: n/a (wiring only). Backpressure: start is only honoured while busy/done are low.
// Carries op 4 regardless of MULDIV_DIV_EN; the unit decides whether it is legal.
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_iter.sv
// One combinational step of shift-add multiply or (MULDIV_DIV_EN) restoring divide.
// Latency: 0 cycles, the caller registers acc_out. Backpressure: none.
// Accumulator layout is {upper, lower}: product-high/multiplier or remainder/quotient.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic                 div_sel,
`endif
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    // The add carry becomes the new top bit as the whole accumulator shifts right.
    always_comb begin
        mul_sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, b} : '0);
        mul_next = {mul_sum, acc_in[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_new;
    logic [2*WIDTH-1:0]   div_next;

    // rem_sh needs WIDTH+1 bits; after a successful subtract the result fits in WIDTH.
    always_comb begin
        rem_sh   = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, b});
        rem_new  = rem_ge ? (rem_sh[WIDTH-1:0] - b) : rem_sh[WIDTH-1:0];
        div_next = {rem_new, acc_in[WIDTH-2:0], rem_ge};
        acc_out  = div_sel ? div_next : mul_next;
    end
`else
    always_comb begin
        acc_out = mul_next;
    end
`endif

endmodule

// File: rtl/muldiv_hilo.sv
// MIPS-style HI/LO unit: MULT/MADD (and DIV with MULDIV_DIV_EN) iterate one bit per cycle.
// Latency: done WIDTH+1 cycles after start for iterative ops, 1 cycle for MTHI/MTLO.
// Backpressure: start is ignored unless IDLE; busy high while iterating.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_hilo_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 op_ok;
    logic                 op_iter;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   madd_sum;

    muldiv_iter #(
        .WIDTH   (WIDTH)
    ) u_iter (
`ifdef MULDIV_DIV_EN
        .div_sel (op_q == OP_DIV),
`endif
        .acc_in  (acc_q),
        .b       (b_q),
        .acc_out (step)
    );

    always_comb begin
        op_ok   = 1'b0;
        op_iter = 1'b0;
        case (bus.op)
            OP_MULT, OP_MADD: begin
                op_ok   = 1'b1;
                op_iter = 1'b1;
            end
            OP_MTHI, OP_MTLO: begin
                op_ok   = 1'b1;
            end
`ifdef MULDIV_DIV_EN
            OP_DIV: begin
                op_ok   = 1'b1;
                op_iter = 1'b1;
            end
`endif
            default: begin
                op_ok   = 1'b0;
                op_iter = 1'b0;
            end
        endcase
    end

    // HI/LO cannot move during RUN, so the MADD addend is the pre-start value.
    assign madd_sum = {hi_q, lo_q} + step;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && op_ok) begin
                    op_d = bus.op;
                    if (op_iter) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, bus.a};
                        b_d     = bus.b;
                    end else begin
                        state_d = ST_DONE;
                        if (bus.op == OP_MTHI) begin
                            hi_d = bus.a;
                        end else begin
                            lo_d = bus.a;
                        end
                    end
                end
            end
            ST_RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                // Last iteration: commit the step result directly on the edge done rises.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (op_q == OP_MADD) begin
                        {hi_d, lo_d} = madd_sum;
                    end else begin
                        {hi_d, lo_d} = step;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            acc_q   <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width in bits (8..64).
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  command strobe, sampled only in IDLE.
REQ-005 op  input  3  command: 0 MULT, 1 MADD, 2 MTHI, 3 MTLO, 4 DIV (only when MULDIV_DIV_EN is defined); 5..7 undefined.
REQ-006 a  input  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 b  input  WIDTH  operand B: multiplier or divisor.
REQ-008 busy  output  1  high while an iterative operation runs.
REQ-009 done  output  1  single-cycle pulse when a command commits.
REQ-010 hi  output  WIDTH  HI register (MFHI source), always readable.
REQ-011 lo  output  WIDTH  LO register (MFLO source), always readable.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start with MULT, MADD or DIV.
- IDLE->DONE on start with MTHI or MTLO.
- RUN->DONE after exactly WIDTH iteration cycles.
- DONE->IDLE unconditionally.
REQ-013 start with an undefined op, or start outside IDLE, SHALL be ignored: no state change, no done.
REQ-014 a, b and op SHALL be latched on the accepted start edge; later input changes have no effect.
REQ-015 MULT: {hi,lo} = a*b, unsigned, 2*WIDTH-bit product, one bit per RUN cycle (shift-add).
REQ-016 MADD: {hi,lo} = {hi,lo} + a*b, unsigned, modulo 2^(2*WIDTH); carry out is discarded.
REQ-017 MTHI writes hi=a; MTLO writes lo=a; the other register is unchanged.
REQ-018 Iterative latency: done SHALL assert WIDTH+1 cycles after the accepted start edge; MTHI/MTLO done SHALL assert 1 cycle after it.
REQ-019 busy SHALL be high in RUN only.
REQ-020 hi/lo SHALL hold their previous values through RUN and update on the same edge on which done rises.
REQ-021 done SHALL be high in DONE only, and for exactly one cycle.
REQ-022 start may be accepted on the cycle after done, giving back-to-back commands.
REQ-023 MADD SHALL use the hi/lo values committed before its start, including an MTHI/MTLO issued immediately before it.

Reset
REQ-024 Under rst: state=IDLE, busy=0, done=0, hi=0, lo=0, and internal accumulators and counters cleared.
REQ-025 rst during RUN or DONE SHALL abort the operation, discard any partial result and suppress done.
REQ-026 rst SHALL take priority over a simultaneous start.

Configuration
REQ-027 Macro MULDIV_DIV_EN defined: op 4 runs a restoring divider producing lo=a/b and hi=a%b, unsigned, WIDTH cycles, same latency as MULT.
REQ-028 MULDIV_DIV_EN defined, divide by zero (b=0): lo = all ones, hi = a, normal latency, no exception.
REQ-029 MULDIV_DIV_EN undefined: op 4 is undefined and ignored per REQ-013; no divider logic is synthesised.

Structure
REQ-030 Package muldiv_pkg SHALL hold the op code constants, the FSM state encoding and the iteration-counter width function, clog2(WIDTH+1).
REQ-031 Sub-module muldiv_iter SHALL hold the per-cycle shift-add / shift-subtract datapath.
REQ-032 muldiv_hilo SHALL own the FSM, the counter, the operand latches and the HI/LO registers.

Verification (WIDTH=32)
REQ-033 MULT a=3, b=5 -> done at start+33, hi=0, lo=15; busy high for cycles 1..32 after start.
REQ-034 MULT a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 MTHI 0, then MTLO 0xFFFFFFFF, then MADD a=1, b=1 -> hi=0x00000001, lo=0x00000000; also MADD from {hi,lo}=all ones with a=1, b=1 -> hi=0, lo=0 (wrap).
REQ-036 MULT 7*9, with start re-pulsed at cycle 5 carrying op=MTLO -> ignored, result lo=63; rst at cycle 10 of a second MULT -> hi=lo=0, busy=0 next cycle, no done.
REQ-037 MULDIV_DIV_EN: DIV 100/7 -> lo=14, hi=2; DIV 100/0 -> lo=0xFFFFFFFF, hi=100; without the macro, op 4 -> no busy, no done, hi/lo unchanged.
